// File: rtl/seg7_scan_mux.sv
// Time-multiplexed 7-segment driver: per-digit scan with blanking gap, per-frame snapshot, leading-zero suppression.
// Optional macro SEG7_HEX_EN: codes 10..15 decode to A,b,C,d,E,F instead of a dash.
module seg7_scan_mux #(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int BLANK_CYCLES   = 16,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);

    localparam int PC_W  = $clog2(SCAN_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PC_W-1:0]       PC_LAST  = PC_W'(SCAN_DIV - 1);
    localparam logic [PC_W-1:0]       PC_BLANK = PC_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_OFF  = {7{SEG_ACTIVE_LOW != 0}};
    localparam logic                  DP_OFF   = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{AN_ACTIVE_LOW != 0}};

    logic [PC_W-1:0]         pc;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] snap_d;
    logic [NUM_DIGITS-1:0]   snap_dp;
    logic                    tick_pend;

    logic                  slot_end;
    logic                  frame_end;
    logic                  in_blank;
    logic                  lz_run;
    logic [NUM_DIGITS-1:0] suppress;
    logic [NUM_DIGITS-1:0] onehot;
    logic [3:0]            cur_code;
    logic                  cur_dp;
    logic                  cur_sup;
    logic [6:0]            seg_raw;

    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] r;
        case (code)
            4'd0:    r = 7'b1111110;
            4'd1:    r = 7'b0110000;
            4'd2:    r = 7'b1101101;
            4'd3:    r = 7'b1111001;
            4'd4:    r = 7'b0110011;
            4'd5:    r = 7'b1011011;
            4'd6:    r = 7'b1011111;
            4'd7:    r = 7'b1110000;
            4'd8:    r = 7'b1111111;
            4'd9:    r = 7'b1111011;
`ifdef SEG7_HEX_EN
            4'd10:   r = 7'b1110111;
            4'd11:   r = 7'b0011111;
            4'd12:   r = 7'b1001110;
            4'd13:   r = 7'b0111101;
            4'd14:   r = 7'b1001111;
            default: r = 7'b1000111;
`else
            default: r = 7'b0000001;
`endif
        endcase
        return r;
    endfunction

    always_comb begin
        slot_end  = (pc == PC_LAST);
        frame_end = slot_end && (idx == IDX_LAST);
        in_blank  = (pc < PC_BLANK);
    end

    // Walk from the most significant digit down; suppression stops at the first nonzero code.
    always_comb begin
        lz_run   = blank_lz;
        suppress = '0;
        for (int unsigned i = 1; i < NUM_DIGITS; i++) begin
            lz_run                 = lz_run && (snap_d[4*(NUM_DIGITS-i) +: 4] == 4'h0);
            suppress[NUM_DIGITS-i] = lz_run;
        end
    end

    always_comb begin
        cur_code = '0;
        cur_dp   = 1'b0;
        cur_sup  = 1'b0;
        onehot   = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            onehot[i] = (idx == IDX_W'(i));
            if (idx == IDX_W'(i)) begin
                cur_code = snap_d[4*i +: 4];
                cur_dp   = snap_dp[i];
                cur_sup  = suppress[i];
            end
        end
        seg_raw = cur_sup ? 7'b0000000 : decode(cur_code);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= '0;
            idx       <= '0;
            snap_d    <= '0;
            snap_dp   <= '0;
            tick_pend <= 1'b0;
        end else if (!en) begin
            pc        <= '0;
            idx       <= '0;
            snap_d    <= digits;
            snap_dp   <= dp;
            tick_pend <= 1'b0;
        end else begin
            tick_pend <= frame_end;
            if (slot_end) begin
                pc <= '0;
                if (frame_end) begin
                    idx     <= '0;
                    snap_d  <= digits;
                    snap_dp <= dp;
                end else begin
                    idx <= idx + 1'b1;
                end
            end else begin
                pc <= pc + 1'b1;
            end
        end
    end

    // seg/dp_out load only at slot start so they never change under a lit anode;
    // frame_tick is delayed one cycle so it coincides with the first digit-0 update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an         <= AN_OFF;
            seg        <= SEG_OFF;
            dp_out     <= DP_OFF;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= en && tick_pend;
            if (!en) begin
                an <= AN_OFF;
            end else begin
                an <= in_blank ? AN_OFF : (onehot ^ AN_OFF);
                if (pc == '0) begin
                    seg    <= seg_raw ^ SEG_OFF;
                    dp_out <= cur_dp ^ DP_OFF;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Self-checking bench for seg7_scan_mux: cycle-count reference model plus directed literal checks and random stimulus.
`timescale 1ns/1ps
module tb_seg7_scan_mux;

    localparam int ND    = 4;
    localparam int SD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = ND * SD;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b1;
    logic        en       = 1'b0;
    logic        blank_lz = 1'b0;
    logic [15:0] digits   = '0;
    logic [3:0]  dp       = '0;
    logic [6:0]  seg;
    logic        dp_out;
    logic [3:0]  an;
    logic        frame_tick;

    int checks = 0;
    int passes = 0;
    bit model_on = 1'b0;

    // Model state: t counts consecutive enabled edges since scanning (re)started.
    int          t;
    logic [15:0] m_snap;
    logic [3:0]  m_snap_dp;
    logic [3:0]  m_an;
    logic [6:0]  m_seg;
    logic        m_dp;
    logic        m_ft;

    seg7_scan_mux #(
        .NUM_DIGITS    (ND),
        .SCAN_DIV      (SD),
        .BLANK_CYCLES  (BC),
        .SEG_ACTIVE_LOW(1),
        .AN_ACTIVE_LOW (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .digits    (digits),
        .dp        (dp),
        .blank_lz  (blank_lz),
        .seg       (seg),
        .dp_out    (dp_out),
        .an        (an),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] raw_of(input logic [3:0] code);
        case (code)
            4'd0: return 7'b1111110;
            4'd1: return 7'b0110000;
            4'd2: return 7'b1101101;
            4'd3: return 7'b1111001;
            4'd4: return 7'b0110011;
            4'd5: return 7'b1011011;
            4'd6: return 7'b1011111;
            4'd7: return 7'b1110000;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1111011;
`ifdef SEG7_HEX_EN
            4'd10: return 7'b1110111;
            4'd11: return 7'b0011111;
            4'd12: return 7'b1001110;
            4'd13: return 7'b0111101;
            4'd14: return 7'b1001111;
            default: return 7'b1000111;
`else
            default: return 7'b0000001;
`endif
        endcase
    endfunction

    // A digit is blank when it and everything above it is zero (digit 0 never).
    function automatic logic [6:0] exp_raw(input logic [15:0] s, input int slot, input logic lz);
        logic [15:0] above;
        above = s >> (4 * slot);
        if (slot > 0 && lz && above == 16'h0) return 7'h00;
        return raw_of(above[3:0]);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t         <= 0;
            m_snap    <= '0;
            m_snap_dp <= '0;
            m_an      <= 4'hF;
            m_seg     <= 7'h7F;
            m_dp      <= 1'b1;
            m_ft      <= 1'b0;
        end else if (!en) begin
            t         <= 0;
            m_snap    <= digits;
            m_snap_dp <= dp;
            m_an      <= 4'hF;
            m_ft      <= 1'b0;
        end else begin
            m_ft <= (t > 0) && (t % FRAME == 0);
            m_an <= ((t % SD) < BC) ? 4'hF : ~(4'b0001 << ((t / SD) % ND));
            if (t % SD == 0) begin
                m_seg <= ~exp_raw(m_snap, (t / SD) % ND, blank_lz);
                m_dp  <= ~m_snap_dp[(t / SD) % ND];
            end
            if (t % FRAME == FRAME - 1) begin
                m_snap    <= digits;
                m_snap_dp <= dp;
            end
            t <= t + 1;
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            check("an", 32'(an), 32'(m_an));
            check("seg", 32'(seg), 32'(m_seg));
            check("dp_out", 32'(dp_out), 32'(m_dp));
            check("frame_tick", 32'(frame_tick), 32'(m_ft));
        end
    end

    initial begin
        int r;
        #1 rst_n = 1'b0;
        model_on = 1'b1;
        #12;
        check("rst_an", 32'(an), 32'h0F);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_dp", 32'(dp_out), 32'h1);
        check("rst_tick", 32'(frame_tick), 32'h0);

        step();
        rst_n  = 1'b1;
        digits = 16'h1234;
        dp     = 4'b0100;
        step(3);
        en = 1'b1;
        step();
        check("scan_d0_seg", 32'(seg), 32'b1001100);
        check("scan_d0_blank", 32'(an), 32'b1111);
        step(2);
        check("scan_d0_an", 32'(an), 32'b1110);
        step(14);
        check("scan_d2_seg", 32'(seg), 32'b0010010);
        check("scan_d2_dp", 32'(dp_out), 32'h0);
        step(2);
        check("scan_d2_an", 32'(an), 32'b1011);
        step(13);
        check("tick_before", 32'(frame_tick), 32'h0);
        step();
        check("tick_frame", 32'(frame_tick), 32'h1);
        check("tick_d0_seg", 32'(seg), 32'b1001100);

        step(11);
        digits = 16'h5678;
        step(5);
        check("coh_d2_seg", 32'(seg), 32'b0010010);
        step(8);
        check("coh_d3_seg", 32'(seg), 32'b1001111);
        step(8);
        check("coh_new_seg", 32'(seg), 32'b0000000);
        check("coh_new_tick", 32'(frame_tick), 32'h1);

        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("en_low_an", 32'(an), 32'b1111);
        end

        digits   = 16'h0045;
        dp       = 4'b0000;
        blank_lz = 1'b1;
        step();
        en = 1'b1;
        step();
        check("lz_d0_seg", 32'(seg), 32'b0100100);
        step(16);
        check("lz_d2_seg", 32'(seg), 32'b1111111);
        step(2);
        check("lz_d2_an", 32'(an), 32'b1011);
        step(6);
        check("lz_d3_seg", 32'(seg), 32'b1111111);
        step(2);
        check("lz_d3_an", 32'(an), 32'b0111);
        en     = 1'b0;
        digits = 16'h0000;
        step();
        en = 1'b1;
        step();
        check("lz_zero_d0", 32'(seg), 32'b0000001);
        step(8);
        check("lz_zero_d1", 32'(seg), 32'b1111111);

        en       = 1'b0;
        digits   = 16'h000A;
        blank_lz = 1'b0;
        step();
        en = 1'b1;
        step();
`ifdef SEG7_HEX_EN
        check("hex_a_seg", 32'(seg), 32'b0001000);
`else
        check("hex_a_seg", 32'(seg), 32'b1111110);
`endif

        step(10);
        #1 rst_n = 1'b0;
        #1;
        check("arst_an", 32'(an), 32'b1111);
        check("arst_seg", 32'(seg), 32'h7F);
        check("arst_dp", 32'(dp_out), 32'h1);
        check("arst_tick", 32'(frame_tick), 32'h0);
        step();
        rst_n = 1'b1;
        step();
        check("arst_restart_blank", 32'(an), 32'b1111);
        step(2);
        check("arst_restart_an", 32'(an), 32'b1110);

        for (int i = 0; i < 700; i++) begin
            r = $urandom_range(0, 99);
            if (r < 10) begin
                digits = 16'($urandom);
                if ($urandom_range(0, 1) == 1) digits = digits & (16'hFFFF >> (4 * $urandom_range(1, 3)));
            end
            if (r < 15) dp = 4'($urandom);
            if (r < 5) blank_lz = ~blank_lz;
            if (r >= 97) en = 1'b0;
            else if (!en && r < 40) en = 1'b1;
            step();
        end

        en = 1'b0;
        step(2);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
